// File: rtl/insn_pkg.sv
// rtl/insn_pkg.sv - instruction encoding constants, type indices and loader state type
package insn_pkg;

    // Primary opcodes, instruction bits [31:27]
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    // R-type ALU operation codes, instruction bits [6:2]
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;
    localparam logic [4:0] ALU_NOP = 5'b01000;

    // Fixed encoding of the nop instruction (aluop 01000, everything else zero)
    localparam logic [31:0] NOP_WORD = 32'h0000_0020;

    // Least-significant bit of each instruction field
    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;

    // Descriptor type index as delivered by the decode side
    typedef enum logic [4:0] {
        T_ADD  = 5'd0,  T_ADDI = 5'd1,  T_SUB  = 5'd2,  T_AND  = 5'd3,
        T_OR   = 5'd4,  T_SLL  = 5'd5,  T_SRA  = 5'd6,  T_MUL  = 5'd7,
        T_DIV  = 5'd8,  T_SW   = 5'd9,  T_LW   = 5'd10, T_J    = 5'd11,
        T_BNE  = 5'd12, T_JAL  = 5'd13, T_JR   = 5'd14, T_BLT  = 5'd15,
        T_BEX  = 5'd16, T_SETX = 5'd17, T_NOP  = 5'd18
    } insn_type_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_PAD   = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/insn_stream_loader_if.sv
// rtl/insn_stream_loader_if.sv - descriptor stream and instruction-memory write bus
interface insn_stream_loader_if #(
    parameter int ADDR_W = 12
) ();
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_type;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_shamt;
    logic [16:0]       in_imm;
    logic [26:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              imem_stall;

    modport master (
        output in_valid, in_type, in_rd, in_rs, in_rt, in_shamt, in_imm, in_target,
        output imem_stall,
        input  in_ready, imem_we, imem_addr, imem_data
    );

    modport slave (
        input  in_valid, in_type, in_rd, in_rs, in_rt, in_shamt, in_imm, in_target,
        input  imem_stall,
        output in_ready, imem_we, imem_addr, imem_data
    );
endinterface

// File: rtl/insn_word_encoder.sv
// rtl/insn_word_encoder.sv - combinational descriptor to 32-bit instruction word encoder
module insn_word_encoder
    import insn_pkg::*;
(
    input  logic [4:0]  in_type,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_shamt,
    input  logic [16:0] in_imm,
    input  logic [26:0] in_target,
    output logic [31:0] word,
    output logic        illegal
);

    function automatic logic [31:0] place(input logic [4:0] v, input int lsb);
        return 32'(v) << lsb;
    endfunction

    logic [31:0] f_rd, f_rs, f_rt, f_sh, f_imm, f_tgt;

    assign f_rd  = place(in_rd, RD_LSB);
    assign f_rs  = place(in_rs, RS_LSB);
    assign f_rt  = place(in_rt, RT_LSB);
    assign f_sh  = place(in_shamt, SHAMT_LSB);
    assign f_imm = 32'(in_imm);
    assign f_tgt = 32'(in_target);

    // Select the fields each type uses; everything else stays zero
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (in_type)
            T_ADD:  word = f_rd | f_rs | f_rt | place(ALU_ADD, ALUOP_LSB);
            T_SUB:  word = f_rd | f_rs | f_rt | place(ALU_SUB, ALUOP_LSB);
            T_AND:  word = f_rd | f_rs | f_rt | place(ALU_AND, ALUOP_LSB);
            T_OR:   word = f_rd | f_rs | f_rt | place(ALU_OR,  ALUOP_LSB);
            T_MUL:  word = f_rd | f_rs | f_rt | place(ALU_MUL, ALUOP_LSB);
            T_DIV:  word = f_rd | f_rs | f_rt | place(ALU_DIV, ALUOP_LSB);
            T_SLL:  word = f_rd | f_rs | f_sh | place(ALU_SLL, ALUOP_LSB);
            T_SRA:  word = f_rd | f_rs | f_sh | place(ALU_SRA, ALUOP_LSB);
            T_ADDI: word = place(OP_ADDI, OPC_LSB) | f_rd | f_rs | f_imm;
            T_SW:   word = place(OP_SW,   OPC_LSB) | f_rd | f_rs | f_imm;
            T_LW:   word = place(OP_LW,   OPC_LSB) | f_rd | f_rs | f_imm;
            T_BNE:  word = place(OP_BNE,  OPC_LSB) | f_rd | f_rs | f_imm;
            T_BLT:  word = place(OP_BLT,  OPC_LSB) | f_rd | f_rs | f_imm;
            T_J:    word = place(OP_J,    OPC_LSB) | f_tgt;
            T_JAL:  word = place(OP_JAL,  OPC_LSB) | f_tgt;
            T_BEX:  word = place(OP_BEX,  OPC_LSB) | f_tgt;
            T_SETX: word = place(OP_SETX, OPC_LSB) | f_tgt;
            T_JR:   word = place(OP_JR,   OPC_LSB) | f_rd;
            T_NOP:  word = NOP_WORD;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/insn_stream_loader.sv
// rtl/insn_stream_loader.sv - encodes descriptors and writes them to imem; LOADER_NOP_PAD_EN appends 4 nops
module insn_stream_loader
    import insn_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              finish,
    insn_stream_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    loader_state_e state_q, state_d;

    // Next address to hand out to an accepted word; bit ADDR_W set means the space is used up
    logic [ADDR_W:0]   acc_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   fill_q;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        in_ready_c, pad_push;
    logic        room, fifo_full, fifo_empty, handshake, push, pop, out_free, write_done, start_ok;
    logic [31:0] push_data;

`ifdef LOADER_NOP_PAD_EN
    logic [2:0] pad_cnt_q;
`endif

    insn_word_encoder u_encoder (
        .in_type   (bus.in_type),
        .in_rd     (bus.in_rd),
        .in_rs     (bus.in_rs),
        .in_rt     (bus.in_rt),
        .in_shamt  (bus.in_shamt),
        .in_imm    (bus.in_imm),
        .in_target (bus.in_target),
        .word      (enc_word),
        .illegal   (enc_illegal)
    );

    assign room       = ~acc_addr_q[ADDR_W];
    assign fifo_full  = (fill_q == DEPTH_C);
    assign fifo_empty = (fill_q == '0);
    assign handshake  = bus.in_valid & in_ready_c;
    assign push       = (handshake & ~enc_illegal) | pad_push;
    assign push_data  = pad_push ? NOP_WORD : enc_word;
    assign out_free   = ~bus.imem_we | ~bus.imem_stall;
    assign pop        = ~fifo_empty & out_free;
    assign write_done = bus.imem_we & ~bus.imem_stall;
    assign start_ok   = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign bus.in_ready = in_ready_c;

    // Loader state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state, handshake readiness and status flags
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        pad_push   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                busy       = 1'b1;
                in_ready_c = ~fifo_full & room;
                if (finish) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
`ifdef LOADER_NOP_PAD_EN
                if (fifo_empty & ~bus.imem_we) state_d = ST_PAD;
`else
                if (fifo_empty & ~bus.imem_we) state_d = ST_DONE;
`endif
            end
`ifdef LOADER_NOP_PAD_EN
            ST_PAD: begin
                busy     = 1'b1;
                pad_push = (pad_cnt_q != 3'd4) & room & ~fifo_full;
                if (((pad_cnt_q == 3'd4) | ~room) & fifo_empty & ~bus.imem_we)
                    state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                done = 1'b1;
                if (start) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef LOADER_NOP_PAD_EN
    // Number of nop words queued in the padding phase of this load
    always_ff @(posedge clock) begin
        if (reset | start_ok) pad_cnt_q <= '0;
        else if (pad_push)    pad_cnt_q <= pad_cnt_q + 3'd1;
    end
`endif

    // Per-load bookkeeping: address allocation, sticky errors, completed-write count
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_addr_q   <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
        end else if (start_ok) begin
            acc_addr_q   <= {1'b0, start_addr};
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
        end else begin
            if (push)
                acc_addr_q <= acc_addr_q + (ADDR_W + 1)'(1);
            if (handshake & enc_illegal)
                err_illegal <= 1'b1;
            if ((state_q == ST_LOAD) & bus.in_valid & ~room)
                err_overflow <= 1'b1;
            if (write_done)
                word_count <= word_count + (ADDR_W + 1)'(1);
        end
    end

    // FIFO storage; entries are only meaningful below the fill level, so no reset
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= push_data;
    end

    // FIFO pointers and fill level
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   fill_q <= fill_q + (PW + 1)'(1);
                2'b01:   fill_q <= fill_q - (PW + 1)'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Output register: holds during a stalled write, otherwise takes the FIFO head
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.imem_we   <= 1'b0;
            bus.imem_addr <= '0;
            bus.imem_data <= '0;
            wr_addr_q     <= '0;
        end else if (start_ok) begin
            wr_addr_q <= start_addr;
        end else if (out_free) begin
            bus.imem_we <= pop;
            if (pop) begin
                bus.imem_addr <= wr_addr_q;
                bus.imem_data <= fifo_mem[rd_ptr_q];
                wr_addr_q     <= wr_addr_q + ADDR_W'(1);
            end
        end
    end

endmodule
